vga_line_fetcher: RTL and testbench

- Upstream pixel source for the 640x480 VGA timing generator.
- Fetches each scanline from the framebuffer memory into a ping-pong line buffer.
- Streams pixels onto the generator's 12-bit rgb input, timed from its line_sync and frame_sync strobes.
- While line k is displayed from one buffer, line k+1 (or line 0 of the next frame) is fetched into the other.

---
 rtl/graphics_pkg.sv | 26 ++
 rtl/line_buffer_dp.sv | 22 ++
 rtl/vga_line_fetcher.sv | 158 +++++++++++++++
 tb/tb_vga_line_fetcher.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/graphics_pkg.sv
// Shared constants and types for the VGA scanline fetch path.
// Covers the display geometry, the lead times and the fetch-engine state encoding.
package graphics_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int PIX_W      = 12;
  localparam int LINE_LEAD  = 4;
  localparam int FRAME_LEAD = 5;

  localparam int X_W   = $clog2(H_ACTIVE + 1);
  localparam int Y_W   = $clog2(V_ACTIVE);
  localparam int LB_AW = $clog2(2 * H_ACTIVE);

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_DRAIN
  } fetch_state_t;

  // Buffer 0 occupies words [0, H_ACTIVE) and buffer 1 occupies [H_ACTIVE, 2*H_ACTIVE).
  function automatic logic [LB_AW-1:0] lb_addr(input logic sel, input logic [X_W-1:0] x);
    return sel ? LB_AW'(x) + LB_AW'(H_ACTIVE) : LB_AW'(x);
  endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Ping-pong scanline storage: two lines side by side in one simple dual-port RAM.
// It has one synchronous write port and one synchronous read port with one cycle of read latency.
module line_buffer_dp
  import graphics_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [LB_AW-1:0] wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [LB_AW-1:0] rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [2*H_ACTIVE];

  // NOTE: the array has no reset so it can map onto block RAM; validity is tracked outside it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_line_fetcher.sv
// Fetches each scanline from the framebuffer into a ping-pong buffer.
// Replays the fetched line to the timing generator with a fixed lead after line_sync or frame_sync.
module vga_line_fetcher
  import graphics_pkg::*;
#(
  parameter int                ADDR_W  = 19,
  parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              line_sync,
  input  logic              frame_sync,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  rgb_out,
  output logic              underrun
);

  fetch_state_t      state, state_nxt;
  logic              pend;
  logic [Y_W-1:0]    pend_line, fetch_line;
  logic [ADDR_W-1:0] pend_base, fetch_base;
  logic [X_W-1:0]    req_x, wr_x;
  logic [1:0]        filled;
  logic [Y_W-1:0]    tag [2];

  logic              synced, lead_run, active, rd_valid;
  logic [Y_W-1:0]    disp_line;
  logic [1:0]        lead_cnt;
  logic [X_W-1:0]    rd_x;
  logic [PIX_W-1:0]  rd_data;

  logic              hs, last_req, wr_en, drain_done;
  logic              line_go, start, ok_buf;
  logic [Y_W-1:0]    start_line, next_line;
  logic [ADDR_W-1:0] next_base;

  assign hs         = mem_req && mem_ready;
  assign last_req   = (req_x == X_W'(H_ACTIVE - 1));
  assign wr_en      = mem_rvalid && (state != F_IDLE) && (wr_x != X_W'(H_ACTIVE));
  assign drain_done = (state == F_DRAIN) && (wr_x == X_W'(H_ACTIVE));
  assign mem_addr   = fetch_base + ADDR_W'(req_x);

  // frame_sync always wins; line_sync only counts once synced and before the last line.
  assign line_go    = synced && line_sync && !frame_sync && (disp_line != Y_W'(V_ACTIVE - 1));
  assign start      = frame_sync || line_go;
  assign start_line = frame_sync ? '0 : disp_line + Y_W'(1);
  assign next_line  = (start_line == Y_W'(V_ACTIVE - 1)) ? '0 : start_line + Y_W'(1);
  assign next_base  = frame_sync ? FB_BASE + ADDR_W'(H_ACTIVE) :
                      (start_line == Y_W'(V_ACTIVE - 1)) ? FB_BASE :
                      pend_base + ADDR_W'(H_ACTIVE);
  assign ok_buf     = filled[start_line[0]] && (tag[start_line[0]] == start_line);

  // NOTE: defaults first so every path assigns each output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    case (state)
      F_IDLE:  if (pend) state_nxt = F_REQ;
      F_REQ: begin
        mem_req = 1'b1;
        if (hs && last_req) state_nxt = F_DRAIN;
      end
      F_DRAIN: if (drain_done) state_nxt = F_IDLE;
      default: state_nxt = F_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state      <= F_IDLE;
      pend       <= 1'b1;
      pend_line  <= '0;
      pend_base  <= FB_BASE;
      fetch_line <= '0;
      fetch_base <= FB_BASE;
      req_x      <= '0;
      wr_x       <= '0;
      filled     <= '0;
      tag[0]     <= '0;
      tag[1]     <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        pend                  <= 1'b1;
        pend_line             <= next_line;
        pend_base             <= next_base;
        filled[~start_line[0]] <= 1'b0;
      end
      if (state == F_IDLE && pend) begin
        fetch_line          <= pend_line;
        fetch_base          <= pend_base;
        filled[pend_line[0]] <= 1'b0;
        if (!start) pend <= 1'b0;
      end
      if (hs) req_x <= last_req ? '0 : req_x + X_W'(1);
      if (wr_en) wr_x <= wr_x + X_W'(1);
      // Completion is written last so it overrides a release of the same buffer this cycle.
      if (drain_done) begin
        wr_x                <= '0;
        filled[fetch_line[0]] <= 1'b1;
        tag[fetch_line[0]]    <= fetch_line;
      end
    end
  end

  // Read address is issued two cycles ahead of rgb_out: RAM latency plus the output register.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      synced    <= 1'b0;
      disp_line <= '0;
      lead_cnt  <= '0;
      lead_run  <= 1'b0;
      active    <= 1'b0;
      rd_x      <= '0;
      rd_valid  <= 1'b0;
      rgb_out   <= '0;
      underrun  <= 1'b0;
    end else begin
      rd_valid <= active;
      rgb_out  <= rd_valid ? rd_data : '0;
      if (start) begin
        synced    <= 1'b1;
        disp_line <= start_line;
        lead_cnt  <= frame_sync ? 2'(FRAME_LEAD - 3) : 2'(LINE_LEAD - 3);
        lead_run  <= 1'b1;
        active    <= 1'b0;
        rd_x      <= '0;
        rd_valid  <= 1'b0;
        rgb_out   <= '0;
        if (!ok_buf) underrun <= 1'b1;
      end else if (lead_run) begin
        lead_cnt <= lead_cnt - 2'd1;
        if (lead_cnt == 2'd1) begin
          lead_run <= 1'b0;
          active   <= 1'b1;
        end
      end else if (active) begin
        if (rd_x == X_W'(H_ACTIVE - 1)) active <= 1'b0;
        else rd_x <= rd_x + X_W'(1);
      end
    end
  end

  line_buffer_dp u_line_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (lb_addr(fetch_line[0], wr_x)),
    .wr_data (mem_rdata),
    .rd_addr (lb_addr(disp_line[0], rd_x)),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed bench for vga_line_fetcher with an in-order framebuffer model returning data = addr[11:0].
// Memory latency and ready pattern are selectable; in-flight responses are flushed with reset.
module tb_vga_line_fetcher;
  import graphics_pkg::*;

  localparam int                ADDR_W  = 19;
  localparam logic [ADDR_W-1:0] FB_BASE = '0;
  localparam int                CAP_N   = FRAME_LEAD + H_ACTIVE + 2;

  logic              clk = 1'b0;
  logic              areset_n = 1'b0;
  logic              line_sync = 1'b0;
  logic              frame_sync = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready = 1'b1;
  logic              mem_rvalid;
  logic [PIX_W-1:0]  mem_rdata;
  logic [PIX_W-1:0]  rgb_out;
  logic              underrun;

  int passed = 0;
  int total  = 0;

  int               lat = 1;
  bit               toggle = 1'b0;
  bit               ready_level = 1'b1;
  logic [3:0]       sr_v = '0;
  logic [PIX_W-1:0] sr_d [4];
  int               base_req_cnt = 0;
  logic [PIX_W-1:0] cap [CAP_N];

  always #20 clk = ~clk;

  vga_line_fetcher #(.ADDR_W(ADDR_W), .FB_BASE(FB_BASE)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .line_sync  (line_sync),
    .frame_sync (frame_sync),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rgb_out    (rgb_out),
    .underrun   (underrun)
  );

  // Framebuffer model: fixed-latency in-order pipeline, flushed by the same reset as the DUT.
  always @(posedge clk) begin
    if (!areset_n) begin
      sr_v      <= '0;
      mem_ready <= ready_level;
    end else begin
      sr_v      <= {sr_v[2:0], mem_req && mem_ready};
      sr_d[0]   <= mem_addr[PIX_W-1:0];
      for (int i = 1; i < 4; i++) sr_d[i] <= sr_d[i-1];
      mem_ready <= toggle ? ~mem_ready : ready_level;
      if (mem_req && mem_ready && mem_addr == FB_BASE) base_req_cnt <= base_req_cnt + 1;
    end
  end

  assign mem_rvalid = sr_v[lat-1];
  assign mem_rdata  = sr_d[lat-1];

  function automatic logic [PIX_W-1:0] pix(input int k, input int x);
    logic [ADDR_W-1:0] a;
    a = FB_BASE + ADDR_W'(k * H_ACTIVE + x);
    return a[PIX_W-1:0];
  endfunction

  // Mismatches of a captured line against line k, including the zero cycles either side.
  function automatic int line_errs(input int lead, input int k);
    int e = 0;
    if (cap[lead-1] !== '0) e++;
    if (cap[lead+H_ACTIVE] !== '0) e++;
    for (int x = 0; x < H_ACTIVE; x++) if (cap[lead+x] !== pix(k, x)) e++;
    return e;
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit frame);
    @(negedge clk);
    if (frame) frame_sync = 1'b1;
    else line_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    line_sync  = 1'b0;
  endtask

  // cap[n] holds rgb_out during the n-th cycle after the strobe cycle.
  task automatic strobe_capture(input bit frame, input int ncyc);
    pulse(frame);
    cap[1] = rgb_out;
    for (int n = 2; n <= ncyc; n++) begin
      @(negedge clk);
      cap[n] = rgb_out;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    areset_n = 1'b0;
    wait_neg(n);
    areset_n = 1'b1;
  endtask

  task automatic test_reset();
    wait_neg(3);
    total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req); else passed++;
    total++; if (mem_addr !== FB_BASE) $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, FB_BASE); else passed++;
    total++; if (rgb_out !== '0) $display("FAIL reset_rgb: got %h expected 000", rgb_out); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b expected 0", underrun); else passed++;
    areset_n = 1'b1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== FB_BASE)
      $display("FAIL first_fetch: got req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, FB_BASE);
    else passed++;
  endtask

  task automatic test_unsynced();
    int bad = 0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      line_sync = (n == 100 || n == 300 || n == 500);
      if (rgb_out !== '0) bad++;
    end
    line_sync = 1'b0;
    total++; if (bad !== 0) $display("FAIL unsynced_rgb: got %0d nonzero cycles expected 0", bad); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL unsynced_idle: got mem_req=%b expected 0", mem_req); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL unsynced_underrun: got %b expected 0", underrun); else passed++;
  endtask

  task automatic test_frame_start();
    int e;
    strobe_capture(1'b1, FRAME_LEAD + H_ACTIVE + 1);
    total++; if (cap[4] !== 12'h000) $display("FAIL frame_t4: got %h expected 000", cap[4]); else passed++;
    total++; if (cap[5] !== 12'h000) $display("FAIL frame_px0: got %h expected 000", cap[5]); else passed++;
    total++; if (cap[644] !== 12'h27F) $display("FAIL frame_px639: got %h expected 27f", cap[644]); else passed++;
    total++; if (cap[645] !== 12'h000) $display("FAIL frame_after: got %h expected 000", cap[645]); else passed++;
    e = line_errs(FRAME_LEAD, 0);
    total++; if (e !== 0) $display("FAIL frame_line0: got %0d bad pixels expected 0", e); else passed++;
    wait_neg(150);
  endtask

  task automatic test_line_sync();
    int e;
    strobe_capture(1'b0, LINE_LEAD + H_ACTIVE + 1);
    total++; if (cap[4] !== 12'h280) $display("FAIL line1_px0: got %h expected 280", cap[4]); else passed++;
    total++; if (cap[324] !== 12'h3C0) $display("FAIL line1_px320: got %h expected 3c0", cap[324]); else passed++;
    total++; if (cap[643] !== 12'h4FF) $display("FAIL line1_px639: got %h expected 4ff", cap[643]); else passed++;
    e = line_errs(LINE_LEAD, 1);
    total++; if (e !== 0) $display("FAIL line1_full: got %0d bad pixels expected 0", e); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL line1_underrun: got %b expected 0", underrun); else passed++;
  endtask

  task automatic test_ready_toggle();
    int e;
    @(negedge clk);
    areset_n = 1'b0;
    lat      = 3;
    toggle   = 1'b1;
    wait_neg(2);
    areset_n = 1'b1;
    wait_neg(1500);
    for (int k = 0; k < 3; k++) begin
      strobe_capture(k == 0, (k == 0 ? FRAME_LEAD : LINE_LEAD) + H_ACTIVE + 1);
      e = line_errs(k == 0 ? FRAME_LEAD : LINE_LEAD, k);
      total++; if (e !== 0) $display("FAIL toggle_line%0d: got %0d bad pixels expected 0", k, e); else passed++;
      wait_neg(750);
    end
    total++; if (underrun !== 1'b0) $display("FAIL toggle_underrun: got %b expected 0", underrun); else passed++;
  endtask

  task automatic test_underrun();
    @(negedge clk);
    areset_n = 1'b0;
    lat      = 1;
    toggle   = 1'b0;
    wait_neg(2);
    areset_n = 1'b1;
    wait_neg(700);
    pulse(1'b1);
    wait_neg(100);
    ready_level = 1'b0;
    wait_neg(700);
    total++; if (underrun !== 1'b0) $display("FAIL underrun_before: got %b expected 0", underrun); else passed++;
    pulse(1'b0);
    wait_neg(2);
    total++; if (underrun !== 1'b1) $display("FAIL underrun_set: got %b expected 1", underrun); else passed++;
    wait_neg(195);
    ready_level = 1'b1;
    wait_neg(1000);
    total++; if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b expected 1", underrun); else passed++;
  endtask

  task automatic test_reset_mid_line();
    pulse(1'b0);
    wait_neg(300);
    do_reset(1);
    total++; if (mem_req !== 1'b0) $display("FAIL midreset_req: got %b expected 0", mem_req); else passed++;
    total++; if (rgb_out !== '0) $display("FAIL midreset_rgb: got %h expected 000", rgb_out); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL midreset_underrun: got %b expected 0", underrun); else passed++;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== FB_BASE)
      $display("FAIL midreset_refetch: got req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, FB_BASE);
    else passed++;
  endtask

  task automatic test_wrap();
    int e, bad, cnt0;
    wait_neg(700);
    strobe_capture(1'b1, FRAME_LEAD + H_ACTIVE + 1);
    e = line_errs(FRAME_LEAD, 0);
    total++; if (e !== 0) $display("FAIL wrap_line0: got %0d bad pixels expected 0", e); else passed++;
    for (int k = 1; k < V_ACTIVE; k++) begin
      pulse(1'b0);
      @(negedge clk);
    end
    cnt0 = base_req_cnt;
    wait_neg(700);
    pulse(1'b0);
    bad = 0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (rgb_out !== '0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL wrap_ignored_rgb: got %0d nonzero cycles expected 0", bad); else passed++;
    total++;
    if (base_req_cnt - cnt0 !== 1)
      $display("FAIL wrap_refetch_base: got %0d requests at base expected 1", base_req_cnt - cnt0);
    else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL wrap_idle: got mem_req=%b expected 0", mem_req); else passed++;
    strobe_capture(1'b1, FRAME_LEAD + H_ACTIVE + 1);
    e = line_errs(FRAME_LEAD, 0);
    total++; if (e !== 0) $display("FAIL wrap_next_frame: got %0d bad pixels expected 0", e); else passed++;
  endtask

  initial begin
    test_reset();
    test_unsynced();
    test_frame_start();
    test_line_sync();
    test_ready_toggle();
    test_underrun();
    test_reset_mid_line();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
